// File: rtl/letter_serial_pkg.sv
// Shared types and frame constants for the letter serial transmitter.
package letter_serial_pkg;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 4;
    localparam int unsigned DATA_BITS            = 8;
    localparam logic        START_LEVEL          = 1'b0;
    localparam logic        STOP_LEVEL           = 1'b1;

endpackage

// File: rtl/letter_serial_tx_if.sv
// Valid/ready letter handshake between the letter source and the transmitter.
interface letter_serial_tx_if;

    logic [7:0] letter;
    logic       letter_valid;
    logic       letter_ready;

    modport master (output letter, output letter_valid, input letter_ready);
    modport slave  (input letter, input letter_valid, output letter_ready);

endinterface

// File: rtl/bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

    logic [7:0] count_q;

    assign tick = (count_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || restart || tick) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 8'd1;
        end
    end

endmodule

// File: rtl/letter_serial_tx.sv
// 8N1 serial transmitter with a one-entry hold register for back-to-back frames.
module letter_serial_tx
    import letter_serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                    CLK,
    input  logic                    RST,
    letter_serial_tx_if.slave       lif,
    output logic                    tx,
    output logic                    busy,
    output logic                    frame_done,
    output logic [15:0]             frames_sent
);

    tx_state_e   state_q;
    logic [7:0]  hold_q;
    logic        hold_full_q;
    logic        hold_full_d;
    logic        ready_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_idx_q;
    logic        tx_q;
    logic        frame_done_q;
    logic [15:0] frames_sent_q;

    logic tick;
    logic last_bit;
    logic accept;
    logic state_change;
    logic hold_load;

    assign last_bit = (bit_idx_q == 3'(DATA_BITS - 1));
    assign accept   = lif.letter_valid && ready_q;

    always_comb begin
        state_change = 1'b0;
        unique case (state_q)
            StIdle:          state_change = hold_full_q;
            StStart, StStop: state_change = tick;
            StData:          state_change = tick && last_bit;
            default:         state_change = 1'b0;
        endcase
    end

    // The hold register drains into the shifter when leaving IDLE or ending STOP.
    assign hold_load = state_change && hold_full_q && (state_q == StIdle || state_q == StStop);

    always_comb begin
        hold_full_d = hold_full_q;
        if (accept) begin
            hold_full_d = 1'b1;
        end else if (hold_load) begin
            hold_full_d = 1'b0;
        end
    end

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (CLK),
        .rst     (RST),
        .restart (state_change),
        .tick    (tick)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= StIdle;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            ready_q       <= 1'b0;
            shift_q       <= '0;
            bit_idx_q     <= '0;
            tx_q          <= STOP_LEVEL;
            frame_done_q  <= 1'b0;
            frames_sent_q <= '0;
        end else begin
            hold_full_q  <= hold_full_d;
            ready_q      <= !hold_full_d;
            frame_done_q <= 1'b0;
            if (accept) begin
                hold_q <= lif.letter;
            end
            unique case (state_q)
                StIdle: begin
                    tx_q <= STOP_LEVEL;
                    if (hold_full_q) begin
                        shift_q <= hold_q;
                        tx_q    <= START_LEVEL;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (tick) begin
                        tx_q      <= shift_q[0];
                        bit_idx_q <= '0;
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (tick) begin
                        if (last_bit) begin
                            tx_q    <= STOP_LEVEL;
                            state_q <= StStop;
                        end else begin
                            tx_q      <= shift_q[1];
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                StStop: begin
                    if (tick) begin
                        frame_done_q  <= 1'b1;
                        frames_sent_q <= frames_sent_q + 16'd1;
                        if (hold_full_q) begin
                            shift_q <= hold_q;
                            tx_q    <= START_LEVEL;
                            state_q <= StStart;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign lif.letter_ready = ready_q;
    assign tx               = tx_q;
    assign busy             = (state_q != StIdle) || hold_full_q;
    assign frame_done       = frame_done_q;
    assign frames_sent      = frames_sent_q;

endmodule

// File: tb/tb_letter_serial_tx.sv
// Directed self-checking bench for letter_serial_tx with CLKS_PER_BIT = 4.
module tb_letter_serial_tx;

    localparam int unsigned CPB = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        tx;
    logic        busy;
    logic        frame_done;
    logic [15:0] frames_sent;

    letter_serial_tx_if lif();

    letter_serial_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .lif         (lif),
        .tx          (tx),
        .busy        (busy),
        .frame_done  (frame_done),
        .frames_sent (frames_sent)
    );

    always #5 CLK = ~CLK;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic tx_log[$];
    int   fd_cnt   = 0;

    always @(negedge CLK) begin
        tx_log.push_back(tx);
        if (frame_done) fd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected line: start, 8 data bits LSB first, stop, each CPB samples, then idle high.
    task automatic check_stream(input string tag, input int base, input logic [7:0] b[$]);
        logic exp_q[$];
        logic e;
        int   i;
        int   errs;
        errs = 0;
        foreach (b[n]) begin
            for (int j = 0; j < 10; j++) begin
                if (j == 0) e = 1'b0;
                else if (j == 9) e = 1'b1;
                else e = b[n][j-1];
                for (int c = 0; c < int'(CPB); c++) exp_q.push_back(e);
            end
        end
        exp_q.push_back(1'b1);
        i = base;
        while (i < tx_log.size() && tx_log[i] == 1'b1) i++;
        check({tag, "_len"}, 32'(tx_log.size() - i >= exp_q.size()), 32'd1);
        foreach (exp_q[k]) begin
            if (i + k >= tx_log.size() || tx_log[i + k] !== exp_q[k]) errs++;
        end
        check({tag, "_bits"}, errs, 0);
    endtask

    // Called just after a negedge; holds valid high until every byte is accepted.
    task automatic drive(input string tag, input logic [7:0] b[$], input bit junk);
        int   idx;
        int   guard;
        int   ready_err;
        logic took;
        idx       = 0;
        guard     = 0;
        ready_err = 0;
        while (idx < b.size() && guard < 3000) begin
            lif.letter_valid = 1'b1;
            lif.letter       = (junk && !lif.letter_ready) ? 8'hFF : b[idx];
            took             = lif.letter_ready;
            @(negedge CLK);
            if (took) begin
                idx++;
                if (lif.letter_ready) ready_err++;
            end
            guard++;
        end
        lif.letter_valid = 1'b0;
        check({tag, "_accepted"}, idx, b.size());
        check({tag, "_ready_low"}, ready_err, 0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_idle"}, busy, 0);
        repeat (5) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        lif.letter_valid = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] msg[$];
        int         base;
        int         fd0;
        int         errs;

        lif.letter       = 8'h00;
        lif.letter_valid = 1'b0;

        repeat (3) @(negedge CLK);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", lif.letter_ready, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frames", frames_sent, 0);
        RST = 1'b0;
        @(negedge CLK);
        check("ready_first_edge", lif.letter_ready, 1);

        errs = 0;
        repeat (20) begin
            @(negedge CLK);
            if (tx !== 1'b1 || busy !== 1'b0 || lif.letter_ready !== 1'b1) errs++;
        end
        check("idle_errs", errs, 0);
        check("idle_frames", frames_sent, 0);

        // Reset during DATA bit 3 of 0x6C with 0x33 waiting in the hold register.
        fd0 = fd_cnt;
        lif.letter       = 8'h6C;
        lif.letter_valid = 1'b1;
        @(negedge CLK);
        check("lat_accept_edge", tx, 1);
        check("hold_full_ready", lif.letter_ready, 0);
        lif.letter = 8'h33;
        @(negedge CLK);
        check("lat_start", tx, 0);
        @(negedge CLK);
        lif.letter_valid = 1'b0;
        repeat (16) @(negedge CLK);
        check("mid_bit3", tx, 1);
        check("mid_busy", busy, 1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_frames", frames_sent, 0);
        base = tx_log.size();
        repeat (60) @(negedge CLK);
        errs = 0;
        for (int k = base; k < tx_log.size(); k++) if (tx_log[k] !== 1'b1) errs++;
        check("abort_line_idle", errs, 0);
        check("abort_no_done", fd_cnt - fd0, 0);
        check("abort_still_idle", busy, 0);

        fd0  = fd_cnt;
        base = tx_log.size();
        msg  = '{8'h48};
        drive("h", msg, 1'b0);
        wait_idle("h");
        check_stream("h", base, msg);
        check("h_done_pulses", fd_cnt - fd0, 1);
        check("h_frames", frames_sent, 1);

        do_reset();
        fd0  = fd_cnt;
        base = tx_log.size();
        msg  = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        drive("hello", msg, 1'b0);
        wait_idle("hello");
        check_stream("hello", base, msg);
        check("hello_done_pulses", fd_cnt - fd0, 5);
        check("hello_frames", frames_sent, 5);

        fd0  = fd_cnt;
        base = tx_log.size();
        msg  = '{8'h41, 8'h42, 8'hFF};
        drive("bp", msg, 1'b1);
        wait_idle("bp");
        check_stream("bp", base, msg);
        check("bp_done_pulses", fd_cnt - fd0, 3);
        check("bp_frames", frames_sent, 8);

        @(negedge CLK);
        force dut.frames_sent_q = 16'hFFFF;
        #1;
        release dut.frames_sent_q;
        @(negedge CLK);
        check("wrap_preload", frames_sent, 16'hFFFF);
        fd0  = fd_cnt;
        base = tx_log.size();
        msg  = '{8'h55};
        drive("wrap", msg, 1'b0);
        wait_idle("wrap");
        check_stream("wrap", base, msg);
        check("wrap_done_pulses", fd_cnt - fd0, 1);
        check("wrap_frames", frames_sent, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
